// File: rtl/aib_driver_ctrl_pkg.sv
// Shared types and constants for the AIB pad driver sequencer.
package aib_drv_ctrl_pkg;

  localparam int AIB_DRV_STR_W = 3;
  localparam logic [AIB_DRV_STR_W-1:0] AIB_DRV_STR_MAX = '1;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RAMP = 2'd1,
    ST_ON   = 2'd2
  } drv_state_e;

  typedef enum logic [1:0] {
    KEEP_NONE = 2'b00,
    KEEP_PU   = 2'b01,
    KEEP_PD   = 2'b10,
    KEEP_RSVD = 2'b11
  } keeper_e;

  function automatic logic [AIB_DRV_STR_W-1:0] str_min(
    input logic [AIB_DRV_STR_W-1:0] a,
    input logic [AIB_DRV_STR_W-1:0] b
  );
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/aib_driver_ctrl_if.sv
// Core-side request and pad-side control bundle of one AIB driver sequencer.
interface aib_driver_ctrl_if;
  import aib_drv_ctrl_pkg::*;

  logic                     tx_en;
  logic                     tx_data;
  logic [AIB_DRV_STR_W-1:0] cfg_pdrv;
  logic [AIB_DRV_STR_W-1:0] cfg_ndrv;
  logic [1:0]               cfg_keeper;
  logic                     C_PU;
  logic [AIB_DRV_STR_W-1:0] C_PDRV;
  logic                     PDRV;
  logic                     C_PD;
  logic [AIB_DRV_STR_W-1:0] C_NDRV;
  logic                     NDRV;
  logic                     tx_ready;

  modport master (
    output tx_en, tx_data, cfg_pdrv, cfg_ndrv, cfg_keeper,
    input  C_PU, C_PDRV, PDRV, C_PD, C_NDRV, NDRV, tx_ready
  );

  modport slave (
    input  tx_en, tx_data, cfg_pdrv, cfg_ndrv, cfg_keeper,
    output C_PU, C_PDRV, PDRV, C_PD, C_NDRV, NDRV, tx_ready
  );

endinterface

// File: rtl/aib_driver_ctrl_deadtime.sv
// Break-before-make generator: holds the driven level and inserts DEADTIME
// cycles with both legs off whenever the sampled data disagrees with it.
module aib_drv_deadtime
  import aib_drv_ctrl_pkg::*;
#(
  parameter int DEADTIME = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_first,
  input  logic i_data,
  output logic o_pdrv,
  output logic o_ndrv
);

  localparam logic [3:0] DT_LAST = 4'(DEADTIME - 1);

  logic       r_samp;
  logic       r_level;
  logic       r_dead;
  logic [3:0] r_dt;
  logic       r_pdrv;
  logic       r_ndrv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_samp  <= 1'b0;
      r_level <= 1'b0;
      r_dead  <= 1'b0;
      r_dt    <= '0;
      r_pdrv  <= 1'b1;
      r_ndrv  <= 1'b0;
    end else begin
      r_samp <= i_data;
      if (!i_en) begin
        r_dead <= 1'b0;
        r_dt   <= '0;
        r_pdrv <= 1'b1;
        r_ndrv <= 1'b0;
      end else if (i_first) begin
        // First drive after enable needs no gap: both legs were already off.
        r_level <= i_data;
        r_dead  <= 1'b0;
        r_dt    <= '0;
        r_pdrv  <= ~i_data;
        r_ndrv  <= ~i_data;
      end else if (r_dead) begin
        if (r_dt != '0) begin
          r_dt   <= r_dt - 4'd1;
          r_pdrv <= 1'b1;
          r_ndrv <= 1'b0;
        end else begin
          r_dead  <= 1'b0;
          r_level <= r_samp;
          r_pdrv  <= ~r_samp;
          r_ndrv  <= ~r_samp;
        end
      end else if (r_samp != r_level) begin
        r_dead <= 1'b1;
        r_dt   <= DT_LAST;
        r_pdrv <= 1'b1;
        r_ndrv <= 1'b0;
      end else begin
        r_pdrv <= ~r_level;
        r_ndrv <= ~r_level;
      end
    end
  end

  assign o_pdrv = r_pdrv;
  assign o_ndrv = r_ndrv;

endmodule

// File: rtl/aib_driver_ctrl.sv
// Sequencer for one AIB pad driver: enable FSM, strength codes, keeper select.
// Soft-start ramp present only when AIB_DRV_CTRL_RAMP_EN is defined.
module aib_driver_ctrl
  import aib_drv_ctrl_pkg::*;
#(
  parameter int DEADTIME      = 1,
  parameter int RAMP_STEP_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  aib_driver_ctrl_if.slave io_bus
);

  localparam int W = AIB_DRV_STR_W;

  if (DEADTIME < 1 || DEADTIME > 15 || RAMP_STEP_CYC < 1 || RAMP_STEP_CYC > 15) begin : g_bad_param
    $error("aib_driver_ctrl: DEADTIME/RAMP_STEP_CYC out of range 1..15");
  end

  drv_state_e r_state, w_state_nxt;
  logic [W-1:0] r_tgt_p, r_tgt_n;
  logic [W-1:0] r_c_pdrv, r_c_ndrv, w_c_pdrv_nxt, w_c_ndrv_nxt;
  logic         r_c_pu, r_c_pd, r_ready, r_first;
  logic         w_c_pu_nxt, w_c_pd_nxt, w_ready_nxt, w_cap;
  logic         w_dt_en;
  keeper_e      w_keep;

  assign w_keep = keeper_e'(io_bus.cfg_keeper);

`ifdef AIB_DRV_CTRL_RAMP_EN
  localparam logic [3:0] STEP_LAST = 4'(RAMP_STEP_CYC - 1);

  logic [W-1:0] r_step, w_max_t;
  logic [3:0]   r_cnt;

  assign w_max_t = (r_tgt_p > r_tgt_n) ? r_tgt_p : r_tgt_n;

  // r_step is the code presented at the next edge; it restarts at 1 on every enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step <= W'(1);
      r_cnt  <= '0;
    end else if (!io_bus.tx_en || r_state != ST_RAMP) begin
      r_step <= W'(1);
      r_cnt  <= '0;
    end else if (r_cnt == STEP_LAST) begin
      r_cnt <= '0;
      if (r_step != AIB_DRV_STR_MAX) r_step <= r_step + W'(1);
    end else begin
      r_cnt <= r_cnt + 4'd1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_OFF;
      r_tgt_p  <= '0;
      r_tgt_n  <= '0;
      r_c_pdrv <= '0;
      r_c_ndrv <= '0;
      r_c_pu   <= 1'b1;
      r_c_pd   <= 1'b0;
      r_ready  <= 1'b0;
      r_first  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_c_pdrv <= w_c_pdrv_nxt;
      r_c_ndrv <= w_c_ndrv_nxt;
      r_c_pu   <= w_c_pu_nxt;
      r_c_pd   <= w_c_pd_nxt;
      r_ready  <= w_ready_nxt;
      r_first  <= io_bus.tx_en && (r_state == ST_OFF);
      if (w_cap) begin
        r_tgt_p <= io_bus.cfg_pdrv;
        r_tgt_n <= io_bus.cfg_ndrv;
      end
    end
  end

  // Outputs follow the current state, except disable which acts on this edge.
  always_comb begin
    w_state_nxt  = r_state;
    w_c_pdrv_nxt = '0;
    w_c_ndrv_nxt = '0;
    w_ready_nxt  = 1'b0;
    w_cap        = 1'b0;
    w_c_pu_nxt   = (w_keep != KEEP_PU);
    w_c_pd_nxt   = (w_keep == KEEP_PD);
    if (!io_bus.tx_en) begin
      w_state_nxt = ST_OFF;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_cap = 1'b1;
`ifdef AIB_DRV_CTRL_RAMP_EN
          w_state_nxt = ST_RAMP;
`else
          w_state_nxt = ST_ON;
`endif
        end
`ifdef AIB_DRV_CTRL_RAMP_EN
        ST_RAMP: begin
          w_c_pu_nxt   = 1'b1;
          w_c_pd_nxt   = 1'b0;
          w_c_pdrv_nxt = str_min(r_step, r_tgt_p);
          w_c_ndrv_nxt = str_min(r_step, r_tgt_n);
          if (r_step >= w_max_t) begin
            w_ready_nxt = 1'b1;
            w_state_nxt = ST_ON;
          end
        end
`endif
        ST_ON: begin
          w_c_pu_nxt   = 1'b1;
          w_c_pd_nxt   = 1'b0;
          w_c_pdrv_nxt = r_tgt_p;
          w_c_ndrv_nxt = r_tgt_n;
          w_ready_nxt  = 1'b1;
        end
        default: w_state_nxt = ST_OFF;
      endcase
    end
  end

  assign w_dt_en = io_bus.tx_en && (r_state != ST_OFF);

  aib_drv_deadtime #(
    .DEADTIME (DEADTIME)
  ) u_deadtime (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_dt_en),
    .i_first (r_first),
    .i_data  (io_bus.tx_data),
    .o_pdrv  (io_bus.PDRV),
    .o_ndrv  (io_bus.NDRV)
  );

  assign io_bus.C_PU     = r_c_pu;
  assign io_bus.C_PD     = r_c_pd;
  assign io_bus.C_PDRV   = r_c_pdrv;
  assign io_bus.C_NDRV   = r_c_ndrv;
  assign io_bus.tx_ready = r_ready;

endmodule
